// File: rtl/rows_writer.sv
// rows_writer: latches a result matrix and writes it row-major, one element per cycle, into RAM
module rows_writer #(
    parameter int N_ROWS     = 3,
    parameter int N_COLUMNS  = 3,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start_write,
    input  logic [ADDR_WIDTH-1:0]                          base_addr,
    input  logic [N_ROWS-1:0][N_COLUMNS-1:0][WIDTH-1:0]    matrix_in,
    input  logic                                           stall,
    output logic                                           write_enable,
    output logic [ADDR_WIDTH-1:0]                          addr,
    output logic [WIDTH-1:0]                               data_out,
    output logic                                           busy,
    output logic                                           finish_write
);
    localparam int TOTAL = N_ROWS * N_COLUMNS;
    localparam int MW    = TOTAL * WIDTH;
    localparam int IW    = $clog2(TOTAL + 1);
    localparam logic [IW-1:0] LAST = IW'(TOTAL);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                r_state, w_state;
    logic [MW-1:0]         r_matrix, w_matrix;
    logic [ADDR_WIDTH-1:0] r_base, w_base;
    logic [IW-1:0]         r_idx, w_idx;
    logic                  r_we, w_we;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [WIDTH-1:0]      r_data, w_data;
    logic                  r_busy, w_busy;
    logic                  r_fin, w_fin;

    // Element [r][c] of the packed matrix sits at flat offset (r*N_COLUMNS+c)*WIDTH,
    // so the row-major index selects it directly without a divide.
    // Next-state and next-output computation for every register
    always_comb begin
        w_state  = r_state;
        w_matrix = r_matrix;
        w_base   = r_base;
        w_idx    = r_idx;
        w_we     = 1'b0;
        w_addr   = r_addr;
        w_data   = r_data;
        w_busy   = r_busy;
        w_fin    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_write) begin
                    w_matrix = matrix_in;
                    w_base   = base_addr;
                    w_idx    = '0;
                    w_busy   = 1'b1;
                    w_state  = WRITE;
                end
            end
            WRITE: begin
                if (r_idx == LAST) begin
                    w_fin   = 1'b1;
                    w_state = DONE;
                end else if (!stall) begin
                    w_we   = 1'b1;
                    w_addr = r_base + ADDR_WIDTH'(r_idx);
                    w_data = r_matrix[r_idx*WIDTH +: WIDTH];
                    w_idx  = r_idx + 1'b1;
                end
            end
            DONE: begin
                w_busy  = 1'b0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously so a transfer stops at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_matrix <= '0;
            r_base   <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_fin    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_matrix <= w_matrix;
            r_base   <= w_base;
            r_idx    <= w_idx;
            r_we     <= w_we;
            r_addr   <= w_addr;
            r_data   <= w_data;
            r_busy   <= w_busy;
            r_fin    <= w_fin;
        end
    end

    assign write_enable = r_we;
    assign addr         = r_addr;
    assign data_out     = r_data;
    assign busy         = r_busy;
    assign finish_write = r_fin;
endmodule

// File: tb/tb_rows_writer.sv
// tb_rows_writer: directed and randomized transfers checked against a per-element write model
module tb_rows_writer;
    typedef logic [2:0][2:0][7:0] mat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_write;
    logic [7:0] base_addr;
    mat_t       matrix_in;
    logic       stall;
    logic       write_enable;
    logic [7:0] addr;
    logic [7:0] data_out;
    logic       busy;
    logic       finish_write;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rows_writer #(.N_ROWS(3), .N_COLUMNS(3), .WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_write  (start_write),
        .base_addr    (base_addr),
        .matrix_in    (matrix_in),
        .stall        (stall),
        .write_enable (write_enable),
        .addr         (addr),
        .data_out     (data_out),
        .busy         (busy),
        .finish_write (finish_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mat_t plan_mat();
        mat_t m;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r][c] = 8'((3 * r + c + 1) * 17);
        return m;
    endfunction

    function automatic mat_t rnd_mat();
        mat_t m;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r][c] = 8'($urandom);
        return m;
    endfunction

    // mode 0: no stall, 1: two stall cycles after the 3rd write, 2: random stall
    task automatic xfer(input logic [7:0] base, input mat_t m, input int mode, input bit mid_start);
        int   issued;
        int   held;
        int   cyc;
        logic s;
        issued = 0;
        held   = 0;
        cyc    = 0;
        start_write = 1'b1;
        base_addr   = base;
        matrix_in   = m;
        stall       = 1'($urandom);
        @(negedge clk);
        chk("accept_busy", busy, 1);
        chk("accept_we", write_enable, 0);
        start_write = 1'b0;
        matrix_in   = rnd_mat();
        base_addr   = 8'($urandom);
        while (issued < 9 && cyc < 200) begin
            s = (mode == 1) ? (issued == 3 && held < 2) :
                (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (mode == 1 && s) held++;
            stall       = s;
            start_write = mid_start && issued == 4;
            if (start_write) begin
                base_addr = 8'h80;
                matrix_in = rnd_mat();
            end
            @(negedge clk);
            cyc++;
            chk("we", write_enable, !s);
            chk("busy", busy, 1);
            chk("fin_early", finish_write, 0);
            if (!s) begin
                chk("addr", addr, 8'(base + issued));
                chk("data", data_out, m[issued / 3][issued % 3]);
                issued++;
            end else if (issued > 0) begin
                chk("hold_addr", addr, 8'(base + issued - 1));
                chk("hold_data", data_out, m[(issued - 1) / 3][(issued - 1) % 3]);
            end
        end
        chk("write_count", issued, 9);
        start_write = 1'b0;
        stall       = 1'($urandom);
        @(negedge clk);
        chk("fin_pulse", finish_write, 1);
        chk("fin_we", write_enable, 0);
        chk("fin_busy", busy, 1);
        stall = 1'($urandom);
        @(negedge clk);
        chk("fin_end", finish_write, 0);
        chk("busy_end", busy, 0);
        chk("end_we", write_enable, 0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_we", write_enable, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        rst         = 1'b0;
        start_write = 1'b0;
        stall       = 1'b0;
        base_addr   = '0;
        matrix_in   = '0;
        repeat (3) @(negedge clk);
        chk("rst_we", write_enable, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fin", finish_write, 0);
        rst = 1'b1;
        @(negedge clk);

        xfer(8'h10, plan_mat(), 0, 1'b0);
        xfer(8'h10, plan_mat(), 1, 1'b0);
        xfer(8'hFE, plan_mat(), 0, 1'b0);
        xfer(8'h10, plan_mat(), 0, 1'b1);

        start_write = 1'b1;
        base_addr   = 8'h40;
        matrix_in   = rnd_mat();
        @(negedge clk);
        start_write = 1'b0;
        stall       = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_we", write_enable, 1);
        rst = 1'b0;
        #1;
        chk("async_we", write_enable, 0);
        chk("async_addr", addr, 0);
        chk("async_data", data_out, 0);
        chk("async_busy", busy, 0);
        chk("async_fin", finish_write, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_we", write_enable, 0);
            chk("post_rst_busy", busy, 0);
        end
        xfer(8'h55, rnd_mat(), 0, 1'b0);

        repeat (4) xfer(8'($urandom), rnd_mat(), 2, 1'b0);

        rst         = 1'b0;
        start_write = 1'b1;
        @(negedge clk);
        chk("rst_vs_start", busy, 0);
        rst         = 1'b1;
        start_write = 1'b0;
        @(negedge clk);
        chk("rst_vs_start_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
